// File: rtl/z80_rom_arb.sv
// Arbitrates the 64-byte micro-code ROM between Z80 reads and a debug read port,
// sequencing the ROM's two-edge registered read and holding the CPU in WAIT meanwhile.
module z80_rom_arb #(
   parameter int unsigned AW       = 6,
   parameter logic [7:0]  OOR_DATA = 8'hFF
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          cpu_mreq_n,
   input  logic          cpu_rd_n,
   input  logic [15:0]   cpu_addr,
   output logic          cpu_wait_n,
   output logic [7:0]    cpu_data,
   output logic          cpu_data_oe,
   input  logic          dbg_req,
   input  logic [AW-1:0] dbg_addr,
   output logic          dbg_ack,
   output logic [7:0]    dbg_data,
   output logic          rom_ce,
   output logic          rom_oe,
   output logic [AW-1:0] rom_addr,
   input  logic [7:0]    rom_data
);

   typedef enum logic [1:0] {StIdle, StAddr, StFetch, StLatch} state_e;
   typedef enum logic {OwnCpu = 1'b0, OwnDbg = 1'b1} owner_e;

   state_e        state_q, state_d;
   owner_e        owner_q, owner_d;
   owner_e        last_q, last_d;
   logic          cpu_done_q, cpu_done_d;
   logic [7:0]    cpu_data_q, cpu_data_d;
   logic [7:0]    dbg_data_q, dbg_data_d;
   logic          dbg_ack_q, dbg_ack_d;
   logic [AW-1:0] rom_addr_q, rom_addr_d;

   logic rd_act;
   logic cpu_pend;
   logic dbg_pend;
   logic cpu_oor;
   logic grant_cpu;
   logic grant_dbg;
   logic capture_cpu;
   logic rom_en;

   assign rd_act   = !cpu_mreq_n && !cpu_rd_n;
   assign cpu_pend = rd_act && !cpu_done_q;
   assign dbg_pend = dbg_req;
   assign cpu_oor  = |cpu_addr[15:AW];

   // On a tie the requester that did not go last wins.
   assign grant_cpu = cpu_pend && (!dbg_pend || (last_q == OwnDbg));
   assign grant_dbg = dbg_pend && !grant_cpu;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= StIdle;
         owner_q    <= OwnCpu;
         last_q     <= OwnDbg;
         cpu_done_q <= 1'b0;
         cpu_data_q <= 8'h00;
         dbg_data_q <= 8'h00;
         dbg_ack_q  <= 1'b0;
         rom_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         cpu_done_q <= cpu_done_d;
         cpu_data_q <= cpu_data_d;
         dbg_data_q <= dbg_data_d;
         dbg_ack_q  <= dbg_ack_d;
         rom_addr_q <= rom_addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if ((grant_cpu && !cpu_oor) || grant_dbg) begin
               state_d = StAddr;
            end
         end
         StAddr:  state_d = StFetch;
         StFetch: state_d = StLatch;
         StLatch: state_d = StIdle;
      endcase
   end

   always_comb begin
      owner_d     = owner_q;
      last_d      = last_q;
      rom_addr_d  = rom_addr_q;
      cpu_data_d  = cpu_data_q;
      dbg_data_d  = dbg_data_q;
      dbg_ack_d   = 1'b0;
      capture_cpu = 1'b0;

      if (state_q == StIdle) begin
         // Out-of-window reads complete at once without touching the ROM or `last`.
         if (grant_cpu && cpu_oor) begin
            cpu_data_d  = OOR_DATA;
            capture_cpu = 1'b1;
         end else if (grant_cpu) begin
            owner_d    = OwnCpu;
            rom_addr_d = cpu_addr[AW-1:0];
         end else if (grant_dbg) begin
            owner_d    = OwnDbg;
            rom_addr_d = dbg_addr;
         end
      end

      if (state_q == StLatch) begin
         last_d = owner_q;
         if (owner_q == OwnDbg) begin
            dbg_data_d = rom_data;
            dbg_ack_d  = 1'b1;
         end else if (rd_act) begin
            cpu_data_d  = rom_data;
            capture_cpu = 1'b1;
         end
      end

      // An aborted CPU read never sets done; done drops as soon as the cycle ends.
      cpu_done_d = rd_act && (cpu_done_q || capture_cpu);
   end

   always_comb begin
      rom_en = 1'b0;
      unique case (state_q)
         StAddr, StFetch: rom_en = 1'b1;
         StIdle, StLatch: rom_en = 1'b0;
      endcase
   end

   assign rom_ce      = rom_en;
   assign rom_oe      = rom_en;
   assign rom_addr    = rom_addr_q;
   assign cpu_wait_n  = !(rd_act && !cpu_done_q);
   assign cpu_data_oe = rd_act && cpu_done_q;
   assign cpu_data    = cpu_data_q;
   assign dbg_ack     = dbg_ack_q;
   assign dbg_data    = dbg_data_q;

endmodule

// File: tb/tb_z80_rom_arb.sv
// Bench for z80_rom_arb: directed scenarios plus random Z80/debug traffic, with every
// cycle compared against a transaction-level model of the arbiter and ROM.
module tb_z80_rom_arb;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          cpu_mreq_n = 1'b1;
   logic          cpu_rd_n = 1'b1;
   logic [15:0]   cpu_addr = 16'h0000;
   logic          cpu_wait_n;
   logic [7:0]    cpu_data;
   logic          cpu_data_oe;
   logic          dbg_req = 1'b0;
   logic [AW-1:0] dbg_addr = '0;
   logic          dbg_ack;
   logic [7:0]    dbg_data;
   logic          rom_ce;
   logic          rom_oe;
   logic [AW-1:0] rom_addr;
   logic [7:0]    rom_data = 8'hA5;

   int n_checks = 0;
   int n_fail = 0;
   int ce_cnt = 0;
   bit mon_en = 0;
   logic [7:0] mem [64];

   always #5 clk = ~clk;

   z80_rom_arb #(.AW(AW), .OOR_DATA(8'hFF)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .cpu_mreq_n  (cpu_mreq_n),
      .cpu_rd_n    (cpu_rd_n),
      .cpu_addr    (cpu_addr),
      .cpu_wait_n  (cpu_wait_n),
      .cpu_data    (cpu_data),
      .cpu_data_oe (cpu_data_oe),
      .dbg_req     (dbg_req),
      .dbg_addr    (dbg_addr),
      .dbg_ack     (dbg_ack),
      .dbg_data    (dbg_data),
      .rom_ce      (rom_ce),
      .rom_oe      (rom_oe),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data)
   );

   // Registered ROM; 8'hA5 stands in for the undriven bus when not enabled.
   always @(posedge clk) rom_data <= (rom_ce && rom_oe) ? mem[rom_addr] : 8'hA5;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Transaction model: a grant occupies the ROM for 3 more cycles, capture on the last.
   wire tb_rd = !cpu_mreq_n && !cpu_rd_n;
   int         m_busy;
   bit         m_owner_dbg, m_last_dbg, m_done, m_ack, m_took, m_ack_n;
   logic [7:0] m_cpu_data, m_dbg_data;
   logic [5:0] m_addr;

   always @(posedge clk) begin
      if (!n_rst) begin
         m_busy = 0; m_owner_dbg = 0; m_last_dbg = 1; m_done = 0; m_ack = 0;
         m_cpu_data = 8'h00; m_dbg_data = 8'h00; m_addr = 6'h00;
      end else begin
         m_took = 0;
         m_ack_n = 0;
         if (m_busy == 0) begin
            if (tb_rd && !m_done && (!dbg_req || m_last_dbg)) begin
               if (cpu_addr >= 16'd64) begin
                  m_cpu_data = 8'hFF;
                  m_took = 1;
               end else begin
                  m_busy = 3; m_owner_dbg = 0; m_addr = cpu_addr[5:0];
               end
            end else if (dbg_req) begin
               m_busy = 3; m_owner_dbg = 1; m_addr = dbg_addr;
            end
         end else if (m_busy == 1) begin
            if (m_owner_dbg) begin
               m_dbg_data = mem[m_addr];
               m_ack_n = 1;
            end else if (tb_rd) begin
               m_cpu_data = mem[m_addr];
               m_took = 1;
            end
            m_last_dbg = m_owner_dbg;
            m_busy = 0;
         end else begin
            m_busy = m_busy - 1;
         end
         m_done = tb_rd && (m_done || m_took);
         m_ack = m_ack_n;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         check_eq("m_wait_n", 16'(cpu_wait_n), 16'(!(tb_rd && !m_done)));
         check_eq("m_data_oe", 16'(cpu_data_oe), 16'(tb_rd && m_done));
         check_eq("m_cpu_data", 16'(cpu_data), 16'(m_cpu_data));
         check_eq("m_dbg_ack", 16'(dbg_ack), 16'(m_ack));
         check_eq("m_dbg_data", 16'(dbg_data), 16'(m_dbg_data));
         check_eq("m_rom_ce", 16'(rom_ce), 16'(m_busy >= 2));
         check_eq("m_rom_oe", 16'(rom_oe), 16'(m_busy >= 2));
         check_eq("m_rom_addr", 16'(rom_addr), 16'(m_addr));
      end
      if (rom_ce) ce_cnt++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; dbg_req = 1'b0;
      tick();
      n_rst = 1'b1;
   endtask

   // Read, hold two cycles past completion, release, then check enable-cycle count.
   task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input int exp_edges,
                           input int exp_ce);
      int n;
      n = 0;
      cpu_addr = a; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; ce_cnt = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cpu_wait_n && n < 20);
      check_eq("rd_edges", 16'(n), 16'(exp_edges));
      check_eq("rd_data", 16'(cpu_data), 16'(exp));
      check_eq("rd_oe", 16'(cpu_data_oe), 16'd1);
      #1;
      tick();
      tick();
      cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
      tick();
      check_eq("rd_ce_cycles", 16'(ce_cnt), 16'(exp_ce));
   endtask

   initial begin
      int n;
      bit cpu_act;
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      mem[6'h00] = 8'h3E; mem[6'h1B] = 8'hF5; mem[6'h25] = 8'hC9; mem[6'h12] = 8'hDB;

      @(negedge clk);
      mon_en = 1;
      #1;
      tick();
      n_rst = 1'b1;
      check_eq("rst_wait_n", 16'(cpu_wait_n), 16'd1);
      check_eq("rst_cpu_data", 16'(cpu_data), 16'h00);
      check_eq("rst_rom_ce", 16'(rom_ce), 16'd0);
      check_eq("rst_dbg_ack", 16'(dbg_ack), 16'd0);

      cpu_read(16'h0000, 8'h3E, 4, 2);
      cpu_read(16'h001B, 8'hF5, 4, 2);
      cpu_read(16'h0025, 8'hC9, 4, 2);
      cpu_read(16'h0100, 8'hFF, 1, 0);

      // Simultaneous CPU and debug requests straight out of reset.
      do_reset();
      cpu_addr = 16'h0000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
      dbg_req = 1'b1; dbg_addr = 6'h12;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cpu_wait_n && n < 20);
      check_eq("tie_cpu_edges", 16'(n), 16'd4);
      check_eq("tie_cpu_data", 16'(cpu_data), 16'h3E);
      while (!dbg_ack && n < 30) begin
         @(negedge clk);
         n++;
      end
      check_eq("tie_dbg_edges", 16'(n), 16'd8);
      check_eq("tie_dbg_data", 16'(dbg_data), 16'hDB);
      // Both kept busy: the model checks alternation cycle by cycle.
      #1;
      for (int k = 0; k < 6; k++) begin
         cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
         tick();
         cpu_addr = 16'($urandom_range(0, 63)); cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
         repeat (6) tick();
      end
      cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; dbg_req = 1'b0;
      repeat (5) tick();

      // Memory write cycle: no wait, no ROM access.
      cpu_addr = 16'h0003; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("wr_wait_n", 16'(cpu_wait_n), 16'd1);
         check_eq("wr_rom_ce", 16'(rom_ce), 16'd0);
      end
      cpu_mreq_n = 1'b1;
      tick();

      // Read aborted while the ROM is in its fetch cycle.
      cpu_addr = 16'h001B; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
      tick();
      tick();
      cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
      repeat (3) tick();
      check_eq("abort_data_kept", 16'(cpu_data), 16'(m_cpu_data));
      cpu_read(16'h0025, 8'hC9, 4, 2);

      // Reset during a debug fetch.
      dbg_addr = 6'h05; dbg_req = 1'b1;
      tick();
      tick();
      n_rst = 1'b0; dbg_req = 1'b0;
      tick();
      check_eq("rstmid_ack", 16'(dbg_ack), 16'd0);
      check_eq("rstmid_ce", 16'(rom_ce), 16'd0);
      check_eq("rstmid_dbg_data", 16'(dbg_data), 16'h00);
      check_eq("rstmid_rom_addr", 16'(rom_addr), 16'h00);
      n_rst = 1'b1;
      tick();
      check_eq("rstmid_ack_after", 16'(dbg_ack), 16'd0);

      // Random traffic.
      cpu_act = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         n_rst = ($urandom_range(0, 399) != 0);
         if ($urandom_range(0, 4) == 0) dbg_req = ~dbg_req;
         dbg_addr = 6'($urandom);
         if (cpu_act) begin
            if ((!cpu_rd_n && cpu_wait_n && $urandom_range(0, 1) == 0) ||
                (cpu_rd_n && $urandom_range(0, 2) == 0) || $urandom_range(0, 29) == 0) begin
               cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_act = 0;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            cpu_addr = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
            cpu_mreq_n = 1'b0;
            cpu_rd_n = ($urandom_range(0, 5) == 0);
            cpu_act = 1;
         end
      end
      n_rst = 1'b1; cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; dbg_req = 1'b0;
      repeat (6) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
